// File: rtl/buffer_access_arbiter.sv
// Byte-access arbiter for the single-port 64-byte USB data buffer.
// Owns the ring pointers and occupancy, and steers the single SRAM port to AHB or USB.
module buffer_access_arbiter #(
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int OCC_W    = 7,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ahb_req,
  input  logic              ahb_wr,
  input  logic [7:0]        ahb_wdata,
  input  logic              ahb_lock,
  input  logic              usb_req,
  input  logic              usb_wr,
  input  logic [7:0]        usb_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              ahb_grant,
  output logic              usb_grant,
  output logic              ahb_rvalid,
  output logic              usb_rvalid,
  output logic [7:0]        rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [OCC_W-1:0]  buffer_occupancy,
  output logic              overflow_err,
  output logic              underflow_err
);
  localparam int LCNT_W = $clog2(LOCK_MAX + 1);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [OCC_W-1:0]  occ;
  logic [LCNT_W-1:0] lock_cnt, lock_nxt;
  logic              prio_usb, prio_nxt;
  logic              rv_ahb, rv_usb, rv_zero;

  logic       win_ahb, win_usb, win_any, win_wr;
  logic [7:0] win_data;
  logic       full, empty, do_wr, do_rd;

  assign full  = (occ == OCC_W'(DEPTH));
  assign empty = (occ == '0);

  always_comb begin
    win_ahb  = 1'b0;
    win_usb  = 1'b0;
    lock_nxt = lock_cnt;
    prio_nxt = prio_usb;
    if (!rst && !clear) begin
      if (ahb_req && usb_req) begin
        if (ahb_lock) begin
          // burst lock lets AHB keep the port, but only LOCK_MAX times in a row
          if (lock_cnt < LCNT_W'(LOCK_MAX)) begin
            win_ahb  = 1'b1;
            lock_nxt = lock_cnt + 1'b1;
          end else begin
            win_usb  = 1'b1;
            lock_nxt = '0;
          end
        end else begin
          win_usb  = prio_usb;
          win_ahb  = !prio_usb;
          prio_nxt = !prio_usb;
        end
      end else begin
        win_ahb = ahb_req;
        win_usb = usb_req;
      end
      if (!ahb_lock || !usb_req) lock_nxt = '0;
    end
  end

  assign win_any  = win_ahb | win_usb;
  assign win_wr   = win_usb ? usb_wr : ahb_wr;
  assign win_data = win_usb ? usb_wdata : ahb_wdata;
  assign do_wr    = win_any & win_wr & !full;
  assign do_rd    = win_any & !win_wr & !empty;

  assign ahb_grant     = win_ahb;
  assign usb_grant     = win_usb;
  assign mem_we        = do_wr;
  assign mem_re        = do_rd;
  assign mem_addr      = do_rd ? rptr : (do_wr ? wptr : '0);
  assign mem_wdata     = do_wr ? win_data : 8'h00;
  assign overflow_err  = win_any & win_wr & full;
  assign underflow_err = win_any & !win_wr & empty;

  assign ahb_rvalid       = rv_ahb;
  assign usb_rvalid       = rv_usb;
  assign rdata            = ((rv_ahb | rv_usb) && !rv_zero) ? mem_rdata : 8'h00;
  assign buffer_occupancy = occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      lock_cnt <= '0;
      prio_usb <= 1'b0;
      rv_ahb   <= 1'b0;
      rv_usb   <= 1'b0;
      rv_zero  <= 1'b0;
    end else begin
      rv_ahb  <= win_ahb & !win_wr;
      rv_usb  <= win_usb & !win_wr;
      // an underflowed read still returns a response, forced to zero
      rv_zero <= win_any & !win_wr & empty;
      prio_usb <= prio_nxt;
      if (clear) begin
        wptr     <= '0;
        rptr     <= '0;
        occ      <= '0;
        lock_cnt <= '0;
      end else begin
        lock_cnt <= lock_nxt;
        if (do_wr) begin
          wptr <= wptr + 1'b1;
          occ  <= occ + 1'b1;
        end
        if (do_rd) begin
          rptr <= rptr + 1'b1;
          occ  <= occ - 1'b1;
        end
      end
    end
  end
endmodule
